// File: rtl/iag_pkg.sv
// rtl/iag_pkg.sv - shared encodings and constants for the instruction address generator
package iag_pkg;

  // Redirect source encodings on PC_Select
  localparam logic [1:0] PCSEL_INC  = 2'b00;
  localparam logic [1:0] PCSEL_RA   = 2'b01;
  localparam logic [1:0] PCSEL_TEMP = 2'b10;
  localparam logic [1:0] PCSEL_IPC  = 2'b11;

  // Stage counter value at which fetches happen
  localparam logic [2:0] STAGE_FETCH = 3'd0;

  // Sequential instruction step in bytes
  localparam logic [31:0] PC_STEP = 32'd4;

  // Interrupt sequencing states
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PENDING = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // Instruction addresses are word aligned; low two bits are dropped on load
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_address_generator_if.sv
// rtl/instruction_address_generator_if.sv - PC control inputs and address outputs bundle
interface instruction_address_generator_if;

  logic [2:0]  Stage;
  logic        PC_Enable;
  logic        PC_Enable_Execute_Stage;
  logic        INC_Select;
  logic [1:0]  PC_Select;
  logic [31:0] RA;
  logic [31:0] Immediate;
  logic        IRQ;
  logic [31:0] PC;
  logic [31:0] PC_Temp;
  logic [31:0] IPC;
  logic        IRQ_Ack;
  logic        Misaligned;

  // Control side: drives enables/operands, observes addresses
  modport master (
    output Stage, PC_Enable, PC_Enable_Execute_Stage, INC_Select, PC_Select,
    output RA, Immediate, IRQ,
    input  PC, PC_Temp, IPC, IRQ_Ack, Misaligned
  );

  // Address generator side
  modport slave (
    input  Stage, PC_Enable, PC_Enable_Execute_Stage, INC_Select, PC_Select,
    input  RA, Immediate, IRQ,
    output PC, PC_Temp, IPC, IRQ_Ack, Misaligned
  );

endinterface

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt request latch and vectored-fetch sequencing (only under IAG_INTERRUPT_EN)
`ifdef IAG_INTERRUPT_EN
module irq_sequencer
  import iag_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  input  logic [2:0] stage,
  input  logic       fetch_en,
  input  logic       redirect_en,
  input  logic [1:0] pc_select,
  output logic       take_irq,
  output logic       irq_ack
);

  irq_state_e state_q, state_d;

  // State register; reset drops any latched request
  always_ff @(posedge clk) begin
    if (reset) state_q <= IRQ_IDLE;
    else       state_q <= state_d;
  end

  // Next state and take strobe; entry waits for a fetch at an instruction boundary
  always_comb begin
    state_d  = state_q;
    take_irq = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (irq) state_d = IRQ_PENDING;
      end
      IRQ_PENDING: begin
        if (stage == STAGE_FETCH && fetch_en) begin
          take_irq = 1'b1;
          state_d  = IRQ_SERVICE;
        end
      end
      IRQ_SERVICE: begin
        if (redirect_en && pc_select == PCSEL_IPC) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // Acknowledge is the take strobe delayed one cycle, so it is exactly one cycle wide
  always_ff @(posedge clk) begin
    if (reset) irq_ack <= 1'b0;
    else       irq_ack <= take_irq;
  end

endmodule
`endif

// File: rtl/instruction_address_generator.sv
// rtl/instruction_address_generator.sv - program counter owner; interrupt support enabled by IAG_INTERRUPT_EN
module instruction_address_generator
  import iag_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0040
) (
  input logic Clock,
  input logic Reset,
  instruction_address_generator_if.slave bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_temp_q;
  logic [31:0] ipc_q;
  logic        misaligned_q;
  logic        irq_ack;
  logic        take_irq;

  logic        load_pc;
  logic        load_temp;
  logic [31:0] pc_src;
  logic [31:0] pc_seq;
  logic [31:0] pc_inc;

  assign pc_seq = pc_q + PC_STEP;
  assign pc_inc = pc_q + (bus.INC_Select ? bus.Immediate : PC_STEP);

`ifdef IAG_INTERRUPT_EN
  irq_sequencer u_irq_sequencer (
    .clk         (Clock),
    .reset       (Reset),
    .irq         (bus.IRQ),
    .stage       (bus.Stage),
    .fetch_en    (bus.PC_Enable),
    .redirect_en (bus.PC_Enable_Execute_Stage),
    .pc_select   (bus.PC_Select),
    .take_irq    (take_irq),
    .irq_ack     (irq_ack)
  );

  // Interrupted PC captured on entry so the handler can return to it
  always_ff @(posedge Clock) begin
    if (Reset)         ipc_q <= 32'd0;
    else if (take_irq) ipc_q <= pc_q;
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{bus.IRQ, bus.Stage};
  assign take_irq = 1'b0;
  assign irq_ack  = 1'b0;
  assign ipc_q    = 32'd0;
`endif

  // Select what loads into PC this cycle: interrupt entry, then redirect, then sequential fetch
  always_comb begin
    load_pc   = 1'b0;
    load_temp = 1'b0;
    pc_src    = pc_q;
    if (take_irq) begin
      load_pc = 1'b1;
      pc_src  = IRQ_VECTOR;
    end else if (bus.PC_Enable_Execute_Stage) begin
      // A coincident fetch still captures the return address
      load_temp = bus.PC_Enable;
      case (bus.PC_Select)
        PCSEL_INC: begin
          load_pc = 1'b1;
          pc_src  = pc_inc;
        end
        PCSEL_RA: begin
          load_pc = 1'b1;
          pc_src  = bus.RA;
        end
        PCSEL_TEMP: begin
          load_pc = 1'b1;
          pc_src  = pc_temp_q;
        end
        default: begin
`ifdef IAG_INTERRUPT_EN
          load_pc = 1'b1;
          pc_src  = ipc_q;
`else
          load_pc = 1'b0;
          pc_src  = pc_q;
`endif
        end
      endcase
    end else if (bus.PC_Enable) begin
      load_pc   = 1'b1;
      load_temp = 1'b1;
      pc_src    = pc_seq;
    end
  end

  // PC, return address and alignment flag registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q         <= RESET_PC;
      pc_temp_q    <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      if (load_pc)   pc_q      <= word_align(pc_src);
      if (load_temp) pc_temp_q <= pc_seq;
      misaligned_q <= load_pc && (pc_src[1:0] != 2'b00);
    end
  end

  assign bus.PC         = pc_q;
  assign bus.PC_Temp    = pc_temp_q;
  assign bus.IPC        = ipc_q;
  assign bus.IRQ_Ack    = irq_ack;
  assign bus.Misaligned = misaligned_q;

endmodule
